sram_controller: RTL
====================

Name: sram_controller

Overview:
- Data-memory back end directly downstream of the MEM stage.
- Turns one 32-bit word read/write request into two 16-bit accesses on an external asynchronous SRAM (256K x 16, DE2-class).
- Deasserts `ready` while the access is in flight; the top level inverts `ready` into the MEM freeze that stalls the pipeline.
- Read data is returned to MEM stage on the cycle `ready` rises.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM half-word 0.
- ACCESS_CYCLES, 2: cycles each 16-bit half access is held on the SRAM bus (>=1).
- SRAM_ADDR_W, 18: SRAM address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  word write request; held stable until ready=1
- rd_en  in  1  word read request; held stable until ready=1
- address  in  32  CPU byte address (word aligned)
- write_data  in  32  store data
- read_data  out  32  load data; valid when ready=1 after a read
- ready  out  1  0 = access in progress (pipeline freezes)
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM half-word address
- SRAM_UB_N  out  1  upper byte enable, always 0
- SRAM_LB_N  out  1  lower byte enable, always 0
- SRAM_CE_N  out  1  chip enable, always 0
- SRAM_OE_N  out  1  output enable, active low
- SRAM_WE_N  out  1  write enable, active low

Behaviour:
- Reset is synchronous and active-high: `rst` is sampled only on the rising edge of `clk`.
- Address map:
  - word_idx = (address - BASE_ADDR) >> 2, truncated to SRAM_ADDR_W-1 bits; out-of-range addresses wrap silently.
  - Low half goes to {word_idx,0}; high half goes to {word_idx,1}.
  - address[1:0] is ignored.
- FSM states: IDLE, LO, HI, DONE. A counter cnt runs 0..ACCESS_CYCLES-1.
- IDLE:
  - If wr_en|rd_en: latch op (write wins if both are set), address, write_data; go LO with cnt=0.
  - Otherwise stay in IDLE.
- LO:
  - Drive the low-half address.
  - Write: DQ=wdata[15:0], WE_N=0, OE_N=1.
  - Read: DQ=Z, OE_N=0, WE_N=1.
  - On cnt==ACCESS_CYCLES-1: a read captures DQ into read_data[15:0]; go HI with cnt=0. Otherwise increment cnt.
- HI:
  - Same as LO, using the high-half address and wdata[31:16].
  - Last cycle: a read captures read_data[31:16]; go DONE.
- DONE: SRAM bus idle; go IDLE.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when no request is present.
  - 0 in IDLE when a request is present, and 0 in LO and HI.
- Latency:
  - Request first seen in IDLE at cycle N gives ready=0 for cycles N..N+2*ACCESS_CYCLES and ready=1 at cycle N+2*ACCESS_CYCLES+1.
  - Default: 5 frozen cycles.
- In DONE the pipeline advances on that edge, so the same request is never re-issued. A new request in the following IDLE cycle starts a fresh access (back-to-back allowed).
- SRAM idle levels (IDLE, DONE, reset): WE_N=1, OE_N=1, DQ=Z, SRAM_ADDR=0.
- SRAM control outputs are decoded from state and the latched registers, never directly from pipeline inputs.
- Writes do not modify read_data.
- Reset values: state=IDLE, cnt=0, read_data=0, latched regs=0.
- Reset mid-access:
  - Abort immediately; WE_N=1 from the cycle after the reset edge.
  - A partially written word is left as-is.
  - ready follows the IDLE rule.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the BASE_ADDR default;
  - SRAM data and address width constants, shared with the top-level SRAM model and the testbench.
- No sub-module: the FSM, counter and tri-state driver fit in a single module.
- A behavioural SRAM model lives in the testbench only.

Test Plan:
- Write 0xDEADBEEF at 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; WE_N low 2 cycles per half; ready=0 for 5 cycles, then 1.
- Read 1024 after that write -> OE_N=0, addresses 0 then 1; read_data=0xDEADBEEF on the ready=1 cycle.
- Write 0x12345678 at 1028, then back-to-back read 1028 -> SRAM[2]=0x5678, SRAM[3]=0x1234; read returns 0x12345678; exactly one DONE cycle between accesses.
- wr_en=rd_en=1, address 1032, data 0xCAFEF00D -> treated as a write (SRAM[4]=0xF00D, SRAM[5]=0xCAFE); read_data unchanged.
- rst asserted in HI of a write -> next cycle state IDLE, WE_N=1, DQ=Z, read_data=0; SRAM[low] written, SRAM[high] untouched.
- ACCESS_CYCLES=3 instance, read 1024 -> ready=0 for 7 cycles; the capture happens on the 3rd cycle of each half.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit-to-16-bit SRAM controller: FSM state
// encoding, default CPU base address and SRAM bus geometry. The testbench
// SRAM model uses the same geometry constants.
package sram_controller_pkg;

  localparam int unsigned SRAM_DATA_W     = 16;
  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte offset of a CPU address from the SRAM window base; modular, so
  // addresses below the base wrap instead of saturating.
  function automatic logic [31:0] window_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Data-memory back end: one 32-bit word access becomes two 16-bit accesses
// on an asynchronous SRAM, low half first. ready stays low while the access
// is in flight so the pipeline freezes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | bus idle; a request is latched and the access starts
//   ST_LO   | low half-word on the bus for ACCESS_CYCLES cycles
//   ST_HI   | high half-word on the bus for ACCESS_CYCLES cycles
//   ST_DONE | bus idle, ready=1, pipeline advances past the request
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          SRAM_ADDR_W   = SRAM_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int IDX_W = SRAM_ADDR_W - 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_wr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [31:0]            wdata_q;
  logic [31:0]            read_data_q;

  logic                   req;
  logic                   cnt_last;
  logic [31:0]            word_off;
  logic [IDX_W-1:0]       word_idx;
  logic                   unused_off;

  logic                   dq_oe;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic                   half_hi;

  assign req      = wr_en | rd_en;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Word index within the SRAM; bits above the window and the byte lane
  // bits are dropped, so out-of-range addresses wrap.
  assign word_off   = window_offset(address, BASE_ADDR);
  assign word_idx   = word_off[SRAM_ADDR_W:2];
  assign unused_off = ^{word_off[31:SRAM_ADDR_W+1], word_off[1:0]};

  // State, counter, latched request and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        op_wr_q <= wr_en;
        idx_q   <= word_idx;
        wdata_q <= write_data;
      end
      if (!op_wr_q && cnt_last) begin
        if (state_q == ST_LO) read_data_q[15:0]  <= SRAM_DQ;
        if (state_q == ST_HI) read_data_q[31:16] <= SRAM_DQ;
      end
    end
  end

  // Next-state and hold-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end
      end
      ST_LO: begin
        if (cnt_last) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM bus decode from state and latched registers only; idle levels
  // everywhere outside LO/HI.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    half_hi   = (state_q == ST_HI);
    if (state_q == ST_LO || state_q == ST_HI) begin
      SRAM_ADDR = {idx_q, half_hi};
      dq_out    = half_hi ? wdata_q[31:16] : wdata_q[15:0];
      if (op_wr_q) begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  assign ready     = (state_q == ST_DONE) || (state_q == ST_IDLE && !req);
  assign read_data = read_data_q;

endmodule
